// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the arbitrating multiplexer.
//   MODE_FIXED / MODE_RR : arbitration mode selectors
//   selw(n)              : index width for n channels, never less than 1
package mux_pkg;
   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;
   function automatic int selw(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational fixed-priority / round-robin grant.
//   req_i       : request vector
//   ptr_i       : round-robin start index (ignored in fixed mode)
//   grant_o     : one-hot grant, zero when no request
//   grant_idx_o : index of the granted channel
module rr_grant
   import mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int MODE = MODE_RR,
   localparam int SELW = selw(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [SELW-1:0] ptr_i,
   output logic [N-1:0]    grant_o,
   output logic [SELW-1:0] grant_idx_o
);
   logic [2*N-1:0] dbl;
   logic           found;
   int             start;
   // Searching the doubled vector from the start index upward handles
   // the wrap from N-1 back to 0 without a modulo per position.
   always_comb begin
      dbl         = {req_i, req_i};
      start       = (MODE == MODE_RR) ? int'(ptr_i) : 0;
      found       = 1'b0;
      grant_o     = '0;
      grant_idx_o = '0;
      for (int k = 0; k < 2*N; k++) begin
         if (!found && k >= start && dbl[k]) begin
            found       = 1'b1;
            grant_idx_o = SELW'(k >= N ? k - N : k);
         end
      end
      if (found) grant_o[grant_idx_o] = 1'b1;
   end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrating mux with a registered valid/ready output.
//   in_valid/in_data/in_ready : per-channel request, data, accept
//   force_en/force_sel        : restrict arbitration to one channel
//   out_valid/out_data/out_sel: registered beat and its source channel
//   out_ready                 : consumer accept
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int MODE  = MODE_RR,
   localparam int SELW = selw(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]     in_ready,
   input  logic             force_en,
   input  logic [SELW-1:0]  force_sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [SELW-1:0]  out_sel,
   input  logic             out_ready
);
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_sel_q, out_sel_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [N-1:0]     req, grant, force_mask;
   logic [SELW-1:0]  grant_idx;
   logic             space, xfer;
   // Out-of-range force index yields an empty mask, so nothing is granted.
   assign force_mask = (int'(force_sel) < N) ? ({{(N-1){1'b0}}, 1'b1} << force_sel) : '0;
   assign req        = force_en ? (in_valid & force_mask) : in_valid;
   assign space      = ~out_valid_q | out_ready;
   assign in_ready   = grant & {N{space}};
   assign xfer       = |in_ready;
   rr_grant #(.N(N), .MODE(MODE)) u_grant (
      .req_i       (req),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );
   always_comb begin
      out_valid_d = xfer | (out_valid_q & ~out_ready);
      out_data_d  = xfer ? in_data[grant_idx*WIDTH +: WIDTH] : out_data_q;
      out_sel_d   = xfer ? grant_idx : out_sel_q;
      ptr_d       = (MODE == MODE_RR && xfer) ? ((grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1) : ptr_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of round-robin and fixed-priority instances.
module tb_rr_arb_mux;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   in_valid;
   logic [127:0] in_data;
   logic         force_en;
   logic [1:0]   force_sel;
   logic         out_ready;
   logic [3:0]   rr_in_ready, fp_in_ready;
   logic         rr_out_valid, fp_out_valid;
   logic [31:0]  rr_out_data, fp_out_data;
   logic [1:0]   rr_out_sel, fp_out_sel;
   int total = 0;
   int bad   = 0;
   int rr_seq[5] = '{0, 1, 2, 3, 0};
   int rr_alt[3] = '{1, 3, 1};

   always #5 clk = ~clk;

   rr_arb_mux #(.WIDTH(32), .N(4), .MODE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rr_in_ready), .force_en(force_en), .force_sel(force_sel),
      .out_valid(rr_out_valid), .out_data(rr_out_data), .out_sel(rr_out_sel),
      .out_ready(out_ready)
   );

   rr_arb_mux #(.WIDTH(32), .N(4), .MODE(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(fp_in_ready), .force_en(force_en), .force_sel(force_sel),
      .out_valid(fp_out_valid), .out_data(fp_out_data), .out_sel(fp_out_sel),
      .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid  = 4'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         force_en  = 1'($urandom);
         force_sel = 2'($urandom);
         out_ready = 1'($urandom);
         tick();
      end
      chk("rst_valid", 32'(rr_out_valid), 0);
      chk("rst_data", rr_out_data, 0);
      chk("rst_sel", 32'(rr_out_sel), 0);
      chk("rst_fp_valid", 32'(fp_out_valid), 0);
      in_valid  = 4'hF;
      in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      force_en  = 1'b0;
      force_sel = 2'd0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      #1;
      chk("first_rdy", 32'(rr_in_ready), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_valid", 32'(rr_out_valid), 1);
         chk("rr_sel", 32'(rr_out_sel), 32'(rr_seq[i]));
         chk("rr_data", rr_out_data, 32'hA0 + 32'(rr_seq[i]));
         chk("fp_sel_all", 32'(fp_out_sel), 0);
      end
      in_valid = 4'b1010;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("fp_rdy", 32'(fp_in_ready), 32'h2);
         tick();
         chk("fp_sel", 32'(fp_out_sel), 1);
         chk("fp_data", fp_out_data, 32'hA1);
         chk("rr_alt_sel", 32'(rr_out_sel), 32'(rr_alt[i]));
      end
      out_ready = 1'b0;
      in_valid  = 4'hF;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_rdy", 32'(rr_in_ready), 0);
         chk("bp_fp_rdy", 32'(fp_in_ready), 0);
         tick();
         chk("bp_valid", 32'(rr_out_valid), 1);
         chk("bp_data", rr_out_data, 32'hA1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_rdy", 32'(rr_in_ready), 32'h4);
      tick();
      chk("bp_rel_sel", 32'(rr_out_sel), 2);
      chk("bp_rel_data", rr_out_data, 32'hA2);
      force_en  = 1'b1;
      force_sel = 2'd2;
      #1;
      chk("force_rdy", 32'(rr_in_ready), 32'h4);
      chk("force_fp_rdy", 32'(fp_in_ready), 32'h4);
      tick();
      chk("force_sel", 32'(rr_out_sel), 2);
      chk("force_data", rr_out_data, 32'hA2);
      in_valid = 4'b1011;
      #1;
      chk("force_none_rdy", 32'(rr_in_ready), 0);
      tick();
      chk("force_drop_valid", 32'(rr_out_valid), 0);
      chk("force_hold_sel", 32'(rr_out_sel), 2);
      force_en = 1'b0;
      in_valid = 4'hF;
      tick();
      chk("pre_rst_sel3", 32'(rr_out_sel), 3);
      tick();
      chk("pre_rst_sel0", 32'(rr_out_sel), 0);
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(rr_out_valid), 0);
      chk("arst_data", rr_out_data, 0);
      chk("arst_sel", 32'(rr_out_sel), 0);
      chk("arst_ptr_rdy", 32'(rr_in_ready), 32'h1);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_rst_valid", 32'(rr_out_valid), 1);
      chk("post_rst_sel", 32'(rr_out_sel), 0);
      chk("post_rst_data", rr_out_data, 32'hA0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
